// File: rtl/cmd_pkg.sv
// cmd_pkg: command/reply byte constants, message lengths and FSM encoding for the command channel.
// Message lengths grow by one when CMD_REPLY_CHECKSUM_EN is defined.
package cmd_pkg;
    localparam logic [7:0] CMD_ON    = 8'd79;
    localparam logic [7:0] CMD_OFF   = 8'd111;
    localparam logic [7:0] CMD_QUERY = 8'd63;
    localparam logic [7:0] ACK_CHAR  = 8'd75;
    localparam logic [7:0] ERR_CHAR  = 8'd69;
    localparam logic [7:0] CR_CHAR   = 8'd13;
    localparam logic [7:0] LF_CHAR   = 8'd10;
    localparam logic [7:0] PWR_BASE  = 8'h30;
`ifdef CMD_REPLY_CHECKSUM_EN
    localparam logic [2:0] LEN_ACK = 3'd6;
    localparam logic [2:0] LEN_ERR = 3'd5;
`else
    localparam logic [2:0] LEN_ACK = 3'd5;
    localparam logic [2:0] LEN_ERR = 3'd4;
`endif
    typedef enum logic {IDLE, SEND} state_t;

    function automatic logic is_known(input logic [7:0] c);
        return c == CMD_ON || c == CMD_OFF || c == CMD_QUERY;
    endfunction
endpackage

// File: rtl/cmd_reply_tx_byte_sel.sv
// reply_byte_sel: picks the reply byte for a given message index.
// The checksum slot is only reachable when the lengths include it (CMD_REPLY_CHECKSUM_EN).
module reply_byte_sel
    import cmd_pkg::*;
(
    input  logic [7:0] cmd,
    input  logic       rec,
    input  logic [2:0] idx,
    input  logic       pwr,
    input  logic [7:0] csum,
    output logic [7:0] data
);
    logic [2:0] len;
    always_comb begin
        len  = rec ? LEN_ACK : LEN_ERR;
        data = idx == len - 3'd1 ? LF_CHAR :
               idx == len - 3'd2 ? CR_CHAR :
               idx == 3'd0       ? (rec ? ACK_CHAR : ERR_CHAR) :
               idx == 3'd1       ? cmd :
               (idx == 3'd2 && rec) ? (PWR_BASE | {7'd0, pwr}) : csum;
    end
endmodule

// File: rtl/cmd_reply_tx.sv
// cmd_reply_tx: turns each command byte into an ASCII reply streamed over valid/ready,
// with a one-deep pending slot; CMD_REPLY_CHECKSUM_EN adds an XOR byte before CR.
module cmd_reply_tx
    import cmd_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Cmd,
    input  logic       CmdValid,
    input  logic       ADCPower,
    output logic [7:0] TxData,
    output logic       TxValid,
    input  logic       TxReady,
    output logic       Busy,
    output logic       CmdDropped
);
    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d, pend_q, pend_d, csum_q, csum_d, sel_byte, nxt;
    logic [2:0] idx_q, idx_d, len;
    logic       rec_q, rec_d, pend_v_q, pend_v_d, pwr_q, pwr_d, stall_q, stall_d;
    logic       busy_q, busy_d, drop_q, drop_d, xfer, last, pwr_use;

    // Power is taken live on the first cycle a byte is shown, then frozen while stalled.
    assign pwr_use = stall_q ? pwr_q : ADCPower;

    reply_byte_sel u_sel (
        .cmd (cmd_q),
        .rec (rec_q),
        .idx (idx_q),
        .pwr (pwr_use),
        .csum(csum_q),
        .data(sel_byte)
    );

    always_comb begin
        len      = rec_q ? LEN_ACK : LEN_ERR;
        xfer     = state_q == SEND && TxReady;
        last     = xfer && idx_q == len - 3'd1;
        nxt      = (last && pend_v_q) ? pend_q : Cmd;
        state_d  = state_q;
        cmd_d    = cmd_q;
        rec_d    = rec_q;
        idx_d    = xfer ? idx_q + 3'd1 : idx_q;
        csum_d   = xfer ? csum_q ^ sel_byte : csum_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        drop_d   = 1'b0;
        pwr_d    = pwr_use;
        stall_d  = state_q == SEND && !TxReady;
        if (state_q == IDLE || last) begin
            if ((last && pend_v_q) || CmdValid) begin
                state_d = SEND;
                cmd_d   = nxt;
                rec_d   = is_known(nxt);
                idx_d   = 3'd0;
                csum_d  = 8'd0;
            end else
                state_d = IDLE;
            if (last && pend_v_q) begin
                pend_v_d = CmdValid;
                pend_d   = Cmd;
            end
        end else if (CmdValid) begin
            drop_d   = pend_v_q;
            pend_v_d = 1'b1;
            pend_d   = pend_v_q ? pend_q : Cmd;
        end
        busy_d = state_d != IDLE || pend_v_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            cmd_q    <= 8'd0;
            rec_q    <= 1'b0;
            idx_q    <= 3'd0;
            csum_q   <= 8'd0;
            pend_v_q <= 1'b0;
            pend_q   <= 8'd0;
            pwr_q    <= 1'b0;
            stall_q  <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            rec_q    <= rec_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            pwr_q    <= pwr_d;
            stall_q  <= stall_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign TxValid    = state_q == SEND;
    assign TxData     = TxValid ? sel_byte : 8'd0;
    assign Busy       = busy_q;
    assign CmdDropped = drop_q;
endmodule

// File: tb/tb_cmd_reply_tx.sv
// tb_cmd_reply_tx: message-level reference model plus directed literal checks for cmd_reply_tx.
module tb_cmd_reply_tx;
    logic       Clock = 1'b0, Reset, CmdValid, ADCPower, TxReady, TxValid, Busy, CmdDropped;
    logic [7:0] Cmd, TxData;

    always #5 Clock = ~Clock;

    cmd_reply_tx dut (
        .Clock(Clock), .Reset(Reset), .Cmd(Cmd), .CmdValid(CmdValid), .ADCPower(ADCPower),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .Busy(Busy), .CmdDropped(CmdDropped)
    );

`ifdef CMD_REPLY_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    int vectors = 0, miscompares = 0, drops = 0;
    bit m_live = 0, m_act = 0, m_drop = 0, m_pcap_ok = 0, m_done, m_was;
    byte unsigned m_cmd, m_pcap, m_pend[$], log_q[$];
    int m_idx;
    logic [7:0] exp_b;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic bit known(byte unsigned c);
        return c == 79 || c == 111 || c == 63;
    endfunction

    function automatic int mlen(byte unsigned c);
        return (known(c) ? 5 : 4) + (CS ? 1 : 0);
    endfunction

    function automatic byte unsigned mbyte(byte unsigned c, int i, byte unsigned p);
        byte unsigned m[$];
        byte unsigned x;
        if (known(c)) m = {8'd75, c, p};
        else m = {8'd69, c};
        if (CS) begin
            x = 0;
            foreach (m[k]) x ^= m[k];
            m.push_back(x);
        end
        m.push_back(8'd13);
        m.push_back(8'd10);
        return m[i];
    endfunction

    function automatic void start(byte unsigned c);
        m_act = 1; m_cmd = c; m_idx = 0; m_pcap_ok = 0;
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            m_act = 0; m_drop = 0; m_live = 1;
            m_pend.delete();
        end else if (m_live) begin
            m_done = 0; m_was = m_act; m_drop = 0;
            if (m_act && TxReady) begin
                m_idx++;
                if (m_idx == mlen(m_cmd)) begin m_done = 1; m_act = 0; end
            end
            if (!m_was || m_done) begin
                if (m_done && m_pend.size() > 0) begin
                    start(m_pend.pop_front());
                    if (CmdValid) m_pend.push_back(Cmd);
                end else if (CmdValid) start(Cmd);
            end else if (CmdValid) begin
                if (m_pend.size() > 0) m_drop = 1;
                else m_pend.push_back(Cmd);
            end
        end
    end

    always @(negedge Clock) begin
        if (m_live) begin
            if (m_act && m_idx == 2 && known(m_cmd) && !m_pcap_ok) begin
                m_pcap = 8'h30 + {7'd0, ADCPower};
                m_pcap_ok = 1;
            end
            check("TxValid", TxValid, m_act);
            if (m_act) begin
                exp_b = mbyte(m_cmd, m_idx, m_pcap);
                check("TxData", TxData, exp_b);
            end
            check("Busy", Busy, m_act || m_pend.size() > 0);
            check("CmdDropped", CmdDropped, m_drop);
            if (TxValid && TxReady) log_q.push_back(TxData);
            if (CmdDropped) drops++;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] c);
        Cmd = c; CmdValid = 1; tick(); CmdValid = 0;
    endtask

    task automatic wait_idle(input int n);
        int k = 0;
        while ((Busy || TxValid) && k < n) begin tick(); k++; end
        if (k >= n) check("idle_timeout", Busy | TxValid, 0);
    endtask

    task automatic expect_log(input string n, input byte unsigned e[$]);
        check({n, "_len"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++) check(n, log_q[i], e[i]);
        log_q.delete();
    endtask

    byte unsigned m79[$], m111[$], m63p1[$], m63p0[$], mA[$];

    initial begin
`ifdef CMD_REPLY_CHECKSUM_EN
        m79 = {8'd75, 8'd79, 8'd49, 8'h35, 8'd13, 8'd10};
        m111 = {8'd75, 8'd111, 8'd49, 8'h15, 8'd13, 8'd10};
        m63p1 = {8'd75, 8'd63, 8'd49, 8'h45, 8'd13, 8'd10};
        m63p0 = {8'd75, 8'd63, 8'd48, 8'h44, 8'd13, 8'd10};
        mA = {8'd69, 8'd65, 8'h04, 8'd13, 8'd10};
`else
        m79 = {8'd75, 8'd79, 8'd49, 8'd13, 8'd10};
        m111 = {8'd75, 8'd111, 8'd49, 8'd13, 8'd10};
        m63p1 = {8'd75, 8'd63, 8'd49, 8'd13, 8'd10};
        m63p0 = {8'd75, 8'd63, 8'd48, 8'd13, 8'd10};
        mA = {8'd69, 8'd65, 8'd13, 8'd10};
`endif
        Reset = 1; CmdValid = 0; Cmd = 0; TxReady = 1; ADCPower = 0;
        tick(); tick();
        check("rst_TxValid", TxValid, 0);
        check("rst_TxData", TxData, 0);
        check("rst_Busy", Busy, 0);
        Reset = 0; tick();
        log_q.delete();

        strobe(8'd79);
        check("lat_TxValid", TxValid, 1);
        check("lat_byte0", TxData, 75);
        ADCPower = 1;
        repeat (CS ? 6 : 5) tick();
        check("t1_end_TxValid", TxValid, 0);
        check("t1_end_Busy", Busy, 0);
        expect_log("t1", m79);

        TxReady = 0;
        strobe(8'h41);
        for (int i = 0; i < 20; i++) begin TxReady = i[0]; tick(); end
        TxReady = 1;
        wait_idle(50);
        expect_log("t2", mA);

        drops = 0; TxReady = 0;
        strobe(8'd79); strobe(8'd111); strobe(8'd63);
        repeat (17) tick();
        check("t3_drops", drops, 1);
        TxReady = 1;
        wait_idle(50);
        expect_log("t3", {m79, m111});

        drops = 0;
        strobe(8'd79); strobe(8'd111);
        for (int i = 0; i < 20; i++) begin
            if (TxValid && TxData == 8'd10) begin strobe(8'd63); break; end
            tick();
        end
        wait_idle(80);
        check("t4_drops", drops, 0);
        expect_log("t4", {m79, m111, m63p1});

        strobe(8'd79);
        tick(); tick(); tick();
        Reset = 1; tick(); Reset = 0;
        check("t5_TxValid", TxValid, 0);
        check("t5_Busy", Busy, 0);
        check("t5_TxData", TxData, 0);
        log_q.delete();
        repeat (10) tick();
        check("t5_residual", log_q.size(), 0);

        ADCPower = 0;
        strobe(8'd63);
        wait_idle(50);
        expect_log("t6", m63p0);

        for (int i = 0; i < 3000; i++) begin
            Reset = $urandom_range(0, 599) == 0;
            CmdValid = $urandom_range(0, 5) == 0;
            case ($urandom_range(0, 3))
                0: Cmd = 8'd79;
                1: Cmd = 8'd111;
                2: Cmd = 8'd63;
                default: Cmd = 8'($urandom);
            endcase
            TxReady = $urandom_range(0, 9) < 7;
            if ($urandom_range(0, 7) == 0) ADCPower = ~ADCPower;
            tick();
        end
        Reset = 0; CmdValid = 0; TxReady = 1;
        wait_idle(200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmd_reply_tx.md
Name: cmd_reply_tx

Overview:
- Host-facing reply generator for the serial command channel; the counterpart to the command-decoding FSMs (ADC power on/off) that consume 8-bit Cmd bytes.
- Each received command byte produces one ASCII reply message. Replies go byte-by-byte to the UART transmitter over a valid/ready handshake.
- Replies report acceptance or rejection and the current ADC power state.

Parameters:
- CMD_ON, 8'd79, 'O' (ADC power on command)
- CMD_OFF, 8'd111, 'o' (ADC power off command)
- CMD_QUERY, 8'd63, '?' (status query, no side effect)
- ACK_CHAR, 8'd75, 'K' (first byte of a reply to a recognized command)
- ERR_CHAR, 8'd69, 'E' (first byte of a reply to an unrecognized command)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- Cmd  in  8  command byte from UART receiver
- CmdValid  in  1  one-cycle strobe; Cmd valid this cycle
- ADCPower  in  1  current ADC power state from power FSM
- TxData  out  8  reply byte to UART transmitter
- TxValid  out  1  TxData valid
- TxReady  in  1  transmitter accepts byte when TxValid && TxReady
- Busy  out  1  message in progress or pending command held
- CmdDropped  out  1  one-cycle pulse: command discarded

Behaviour:
- Reset (Clock edge with Reset=1): TxValid=0, TxData=0, Busy=0, CmdDropped=0, pending slot empty, FSM to IDLE. A message in flight is aborted and no further bytes are sent.
- Message format, recognized command (CMD_ON/CMD_OFF/CMD_QUERY): ACK_CHAR, Cmd echo, power byte, 8'd13, 8'd10 (5 bytes).
  - Power byte = 8'h30 + ADCPower, sampled on the cycle that byte is first presented.
- Message format, any other Cmd: ERR_CHAR, Cmd echo, 8'd13, 8'd10 (4 bytes).
- FSM states:
  - IDLE: waiting for a command.
  - SEND: TxValid=1. Byte index counter 0..N-1, next byte selected from latched command and type.
- Latency: CmdValid in IDLE at cycle n gives TxValid=1 with byte 0 at cycle n+1.
- Handshake:
  - TxData and TxValid hold stable until TxValid && TxReady.
  - Index advances on each transfer.
  - TxValid never drops mid-message.
- After the final byte (LF) transfers:
  - Pending slot full: load it and present its byte 0 on the next cycle. Back-to-back, no TxValid gap.
  - Pending slot empty: go to IDLE, TxValid=0 the next cycle.
- One-deep pending slot:
  - CmdValid while in SEND stores Cmd if the slot is empty.
  - If the slot is full, Cmd is discarded and CmdDropped pulses on the next cycle.
- Simultaneous CmdValid and final-byte transfer:
  - Slot full: pending moves to active, new Cmd goes into the slot, no drop.
  - Slot empty: new Cmd becomes the next active message directly.
- Busy = (state != IDLE) || pending valid.
- Busy and CmdDropped are registered outputs.
- Power byte sampling guarantees at least 2 cycles after the command strobe, so the power FSM's updated state is reported.

Optional Feature:
- Macro: CMD_REPLY_CHECKSUM_EN.
- Defined: insert one byte immediately before CR. The byte is the XOR of all preceding message bytes. Messages become 6 bytes (recognized) and 5 bytes (unrecognized).
- Undefined: no checksum byte; formats as above.
- Handshake, pending, and drop rules are unchanged in both builds.

Decomposition:
- Shared package (cmd_pkg):
  - Command byte constants ('O', 'o', '?') shared with the power FSM.
  - ACK/ERR/CR/LF byte constants.
  - FSM state encoding.
  - Message-length constants, including the checksum-build variants.
- Sub-module reply_byte_sel: combinational mux from (latched Cmd, recognized flag, index, ADCPower, running checksum) to the byte value. The top keeps the FSM, counter, pending slot, and handshake.

Test Plan:
- Reset, then Cmd=79 strobe with TxReady=1 constantly, ADCPower rising 1 cycle later -> TxData sequence 75,79,49,13,10 on cycles n+1..n+5; TxValid low at n+6; Busy low after.
- Cmd=8'h41 ('A'), TxReady toggling 1-0-1 -> bytes 69,65,13,10, each held stable while TxReady=0; no byte skipped or repeated.
- Three Cmd strobes (79, 111, 63) on consecutive cycles, TxReady=0 for 20 cycles -> first message active, 111 pending, 63 dropped (CmdDropped pulse once); after TxReady=1, two back-to-back messages with no TxValid gap.
- Cmd strobe coinciding with the final LF transfer, pending full -> pending message starts next cycle, new Cmd enters slot, CmdDropped stays 0.
- Reset asserted after byte 2 transfers -> next cycle TxValid=0, Busy=0, TxData=0; no residual bytes after Reset released.
- With CMD_REPLY_CHECKSUM_EN, Cmd=63, ADCPower=0 -> 75,63,48,(75^63^48)=8'h44,13,10.
